// File: rtl/instr_fetch_decode.sv
// ============================================================================
// Module   : instr_fetch_decode
// Brief    : Fetch/decode front end. Fetches instruction words over an imem
//            req/ack handshake, holds them in the IR, splits out register
//            address fields and control flags, and hands each instruction
//            downstream over valid/ready. Accepts branch redirects.
//            Optional macro IMEM_TIMEOUT_EN: fetch timeout with sticky
//            fetch_err and automatic request reissue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_decode #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [3:0]  addr_rn,
    output logic [3:0]  addr_rd,
    output logic [3:0]  addr_rs,
    output logic [3:0]  addr_rm,
    output logic        rd_write_en,
    output logic        is_branch,
    output logic        is_link,
    output logic [31:0] pc_out,
    output logic [31:0] pc_next,
    output logic        fetch_err
);

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_req  = 2'd1;
    localparam logic [1:0]  c_st_out  = 2'd2;
    localparam logic [31:0] c_pc_step = 32'd4;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_pc_out;
    logic [31:0] r_ir;
    logic [31:0] r_fetch_addr;
    logic        r_drop_pending;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_branch_pc;
    logic        w_capture;
    logic        w_issue;
    logic        w_drop_set;
    logic        w_drop_clr;
    logic        w_timeout;
    logic        w_out;
    logic        w_unused;

    // Redirect targets are always word aligned.
    assign w_branch_pc = {branch_target[31:2], 2'b00};

    // IR bits that no output field uses, plus the ignored target LSBs.
    assign w_unused = ^{r_ir[31:28], r_ir[7:4], branch_target[1:0]};

`ifdef IMEM_TIMEOUT_EN
    logic [7:0] r_to_cnt;
    logic       r_fetch_err;

    assign w_timeout = (r_state == c_st_req) && !imem_ack && (r_to_cnt == TIMEOUT_CYCLES);
    assign fetch_err = r_fetch_err;

    // Wait counter restarts with every issued request; fetch_err is sticky.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt    <= 8'd0;
            r_fetch_err <= 1'b0;
        end else begin
            if (w_issue) begin
                r_to_cnt <= 8'd0;
            end else if ((r_state == c_st_req) && !imem_ack) begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end
            if (w_timeout) begin
                r_fetch_err <= 1'b1;
            end
        end
    end
`else
    logic [7:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign fetch_err        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the datapath strobes that go with each transition.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_issue     = 1'b0;
        w_drop_set  = 1'b0;
        w_drop_clr  = 1'b0;
        w_pc_nxt    = branch_valid ? w_branch_pc : r_pc;
        case (r_state)
            c_st_idle: begin
                w_state_nxt = c_st_req;
                w_issue     = 1'b1;
            end
            c_st_req: begin
                if (imem_ack) begin
                    if (branch_valid || r_drop_pending) begin
                        // Stale word: throw it away and fetch from the new pc.
                        w_issue    = 1'b1;
                        w_drop_clr = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_pc_nxt    = r_pc + c_pc_step;
                        w_state_nxt = c_st_out;
                    end
                end else if (w_timeout) begin
                    // The lost request may still answer later; drop that answer.
                    w_issue    = 1'b1;
                    w_drop_set = 1'b1;
                end else if (branch_valid) begin
                    // Bus request cannot be aborted; discard its eventual ack.
                    w_drop_set = 1'b1;
                end
            end
            c_st_out: begin
                if (branch_valid || dec_ready) begin
                    w_state_nxt = c_st_req;
                    w_issue     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // PC, IR and fetch-address registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc           <= RESET_VECTOR;
            r_pc_out       <= RESET_VECTOR;
            r_ir           <= 32'd0;
            r_fetch_addr   <= 32'd0;
            r_drop_pending <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_capture) begin
                r_ir     <= imem_rdata;
                r_pc_out <= r_pc;
            end
            if (w_issue) begin
                r_fetch_addr <= w_pc_nxt;
            end
            if (w_drop_set) begin
                r_drop_pending <= 1'b1;
            end else if (w_drop_clr) begin
                r_drop_pending <= 1'b0;
            end
        end
    end

    assign w_out = (r_state == c_st_out);

    // Outputs decoded purely from registered state; fields read zero outside OUT.
    always_comb begin
        imem_req    = (r_state == c_st_req);
        imem_addr   = r_fetch_addr;
        dec_valid   = w_out;
        pc_out      = r_pc_out;
        pc_next     = r_pc_out + c_pc_step;
        addr_rn     = 4'd0;
        addr_rd     = 4'd0;
        addr_rs     = 4'd0;
        addr_rm     = 4'd0;
        rd_write_en = 1'b0;
        is_branch   = 1'b0;
        is_link     = 1'b0;
        if (w_out) begin
            addr_rn     = r_ir[19:16];
            addr_rd     = r_ir[15:12];
            addr_rs     = r_ir[11:8];
            addr_rm     = r_ir[3:0];
            // Data processing except TST/TEQ/CMP/CMN (opcode 10xx), or a load.
            rd_write_en = ((r_ir[27:26] == 2'b00) && (r_ir[24:23] != 2'b10)) ||
                          ((r_ir[27:26] == 2'b01) && r_ir[20]);
            is_branch   = (r_ir[27:25] == 3'b101);
            is_link     = (r_ir[27:25] == 3'b101) && r_ir[24];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
// ============================================================================
// Module   : tb_instr_fetch_decode
// Brief    : Self-checking bench for instr_fetch_decode: decode vector table,
//            directed redirect/stall/wrap/reset sequences, and a randomized
//            run against a program-order reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  addr_rn;
    logic [3:0]  addr_rd;
    logic [3:0]  addr_rs;
    logic [3:0]  addr_rm;
    logic        rd_write_en;
    logic        is_branch;
    logic        is_link;
    logic [31:0] pc_out;
    logic [31:0] pc_next;
    logic        fetch_err;

    logic [18:0] dut_fields;
    assign dut_fields = {addr_rn, addr_rd, addr_rs, addr_rm, rd_write_en, is_branch, is_link};

    instr_fetch_decode dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .addr_rn      (addr_rn),
        .addr_rd      (addr_rd),
        .addr_rs      (addr_rs),
        .addr_rm      (addr_rm),
        .rd_write_en  (rd_write_en),
        .is_branch    (is_branch),
        .is_link      (is_link),
        .pc_out       (pc_out),
        .pc_next      (pc_next),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] word;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rm;
        logic        we;
        logic        br;
        logic        lk;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_note(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference decode taken directly from the field/flag rules.
    function automatic logic [18:0] ref_decode(input logic [31:0] w);
        logic        we;
        logic        br;
        int unsigned op;
        op = w[24:21];
        case (w[27:26])
            2'b00:   we = !(op >= 8 && op <= 11);
            2'b01:   we = w[20];
            default: we = 1'b0;
        endcase
        br = (w[27:25] == 3'b101);
        return {w[19:16], w[15:12], w[11:8], w[3:0], we, br, br & w[24]};
    endfunction

    // Pseudo-random but deterministic instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        h = h * 32'h85EB_CA6B;
        h = h ^ (h >> 13);
        return {4'hE, h[27:0]};
    endfunction

    task automatic wait_req(input string name);
        int k;
        k = 0;
        while (!imem_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'd0, imem_req}, 32'd1);
    endtask

    // Return one word on the bus; leaves the bench at the next negedge.
    task automatic fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
    endtask

    task automatic accept;
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic        busy;
        logic [31:0] req_a;
        int          lat;
        logic [31:0] exp_pc;
        logic [31:0] cur_pc;
        logic        prev_valid;
        int          idle;
        int          deliveries;

        tbl[0]  = '{32'hE081_2003, 4'h1, 4'h2, 4'h0, 4'h3, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{32'hE150_0002, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{32'hEB00_0010, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{32'hEA00_0004, 4'h0, 4'h0, 4'h0, 4'h4, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{32'hE591_2004, 4'h1, 4'h2, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{32'hE581_2004, 4'h1, 4'h2, 4'h0, 4'h4, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{32'hE1A0_1002, 4'h0, 4'h1, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{32'hE110_0002, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{32'hE130_0002, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{32'hE170_0002, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{32'hE180_0002, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{32'hE1F0_0002, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{32'hEE00_0010, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{32'hE791_2004, 4'h1, 4'h2, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{32'hE0AB_CDEF, 4'hB, 4'hC, 4'hD, 4'hF, 1'b1, 1'b0, 1'b0};

        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'd0;
        branch_valid  = 1'b0;
        branch_target = 32'd0;
        dec_ready     = 1'b0;

        // ---------------- reset values and first request ----------------
        repeat (3) @(negedge clk);
        chk("rst_req_valid_err", {29'd0, imem_req, dec_valid, fetch_err}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_fields", {13'd0, dut_fields}, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_pc_next", pc_next, 32'd4);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", {31'd0, imem_req}, 32'd1);

        // ---------------- decode vector table ----------------
        for (int i = 0; i < 15; i++) begin
            wait_req("tbl_req");
            chk("tbl_imem_addr", imem_addr, 32'(i * 4));
            fetch(tbl[i].word);
            chk("tbl_valid_after_ack", {31'd0, dec_valid}, 32'd1);
            chk("tbl_fields", {13'd0, dut_fields},
                {13'd0, tbl[i].rn, tbl[i].rd, tbl[i].rs, tbl[i].rm, tbl[i].we, tbl[i].br, tbl[i].lk});
            chk("tbl_pc_out", pc_out, 32'(i * 4));
            chk("tbl_pc_next", pc_next, 32'(i * 4 + 4));
            if (i == 0) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("hold_valid_noreq", {30'd0, dec_valid, imem_req}, 32'd2);
                    chk("hold_fields", {13'd0, dut_fields}, {13'd0, ref_decode(tbl[0].word)});
                    chk("hold_pc_out", pc_out, 32'd0);
                end
            end
            accept();
            chk("req_after_ready", {30'd0, dec_valid, imem_req}, 32'd1);
        end

        // ---------------- branch while a request is in flight ----------------
        chk("brq_addr_before", imem_addr, 32'd60);
        branch_valid  = 1'b1;
        branch_target = 32'h0000_0103;
        @(negedge clk);
        branch_valid = 1'b0;
        chk("brq_req_held", {31'd0, imem_req}, 32'd1);
        chk("brq_addr_stable", imem_addr, 32'd60);
        @(negedge clk);
        chk("brq_addr_stable2", imem_addr, 32'd60);
        fetch(32'hE089_9999);
        chk("brq_dropped", {30'd0, dec_valid, imem_req}, 32'd1);
        chk("brq_redirect_addr", imem_addr, 32'h0000_0100);
        fetch(32'hE081_2003);
        chk("brq_valid", {31'd0, dec_valid}, 32'd1);
        chk("brq_pc_out", pc_out, 32'h0000_0100);
        chk("brq_fields", {13'd0, dut_fields}, {13'd0, ref_decode(32'hE081_2003)});
        accept();

        // ---------------- branch in the same cycle as ack ----------------
        chk("brack_addr_before", imem_addr, 32'h0000_0104);
        branch_valid  = 1'b1;
        branch_target = 32'h0000_0200;
        fetch(32'hE089_9999);
        branch_valid = 1'b0;
        chk("brack_dropped", {30'd0, dec_valid, imem_req}, 32'd1);
        chk("brack_addr", imem_addr, 32'h0000_0200);
        fetch(32'hE150_0002);
        chk("brack_pc_out", pc_out, 32'h0000_0200);
        chk("brack_fields", {13'd0, dut_fields}, {13'd0, ref_decode(32'hE150_0002)});

        // ---------------- branch in OUT with ready, then wrap ----------------
        branch_valid  = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        dec_ready     = 1'b1;
        @(negedge clk);
        branch_valid = 1'b0;
        dec_ready    = 1'b0;
        chk("brout_valid_fall", {30'd0, dec_valid, imem_req}, 32'd1);
        chk("brout_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'hEB00_0010);
        chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap_pc_next", pc_next, 32'd0);
        chk("wrap_fields", {13'd0, dut_fields}, {13'd0, ref_decode(32'hEB00_0010)});
        accept();
        chk("wrap_next_req", {31'd0, imem_req}, 32'd1);
        chk("wrap_next_addr", imem_addr, 32'd0);

        // ---------------- no acknowledge ----------------
`ifdef IMEM_TIMEOUT_EN
        begin
            int k;
            k = 0;
            while (!fetch_err && k < 300) begin
                @(negedge clk);
                k++;
            end
            chk("timeout_err", {31'd0, fetch_err}, 32'd1);
            @(negedge clk);
            chk("timeout_reissue", {30'd0, imem_req, dec_valid}, 32'd2);
            chk("timeout_addr", imem_addr, 32'd0);
        end
`else
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            chk("noack_wait", {30'd0, fetch_err, imem_req}, 32'd1);
        end
        chk("noack_addr", imem_addr, 32'd0);
`endif

        // ---------------- reset mid-request, late ack in IDLE ----------------
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_req_valid_err", {29'd0, imem_req, dec_valid, fetch_err}, 32'd0);
        chk("midrst_pc_out", pc_out, 32'd0);
        rst_n = 1'b1;
        fetch(32'hE089_9999);
        chk("late_ack_ignored", {30'd0, dec_valid, imem_req}, 32'd1);
        chk("late_ack_addr", imem_addr, 32'd0);

        // ---------------- randomized run vs program-order model ----------------
        busy       = 1'b0;
        req_a      = 32'd0;
        lat        = 0;
        exp_pc     = 32'd0;
        cur_pc     = 32'd0;
        prev_valid = 1'b0;
        idle       = 0;
        deliveries = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (dec_valid && !prev_valid) begin
                chk("rnd_pc_out", pc_out, exp_pc);
                cur_pc = exp_pc;
                exp_pc = exp_pc + 32'd4;
                idle   = 0;
                deliveries++;
            end else begin
                idle++;
            end
            if (dec_valid) begin
                chk("rnd_fields", {13'd0, dut_fields}, {13'd0, ref_decode(mem_word(cur_pc))});
                chk("rnd_pc_next", pc_next, cur_pc + 32'd4);
                chk("rnd_noreq_in_out", {31'd0, imem_req}, 32'd0);
            end
            prev_valid = dec_valid;
            if (idle > 60) begin
                fail_note("rnd_progress");
                break;
            end

            imem_ack   = 1'b0;
            imem_rdata = 32'd0;
            if (imem_req) begin
                if (!busy) begin
                    busy  = 1'b1;
                    req_a = imem_addr;
                    lat   = $urandom_range(0, 3);
                end else begin
                    chk("rnd_addr_stable", imem_addr, req_a);
                end
                if (lat == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(req_a);
                    busy       = 1'b0;
                end else begin
                    lat--;
                end
            end
            dec_ready     = ($urandom_range(0, 1) == 1);
            branch_valid  = ($urandom_range(0, 11) == 0);
            branch_target = $urandom_range(0, 32'h3FF);
            if (branch_valid) begin
                exp_pc = branch_target & ~32'd3;
            end
            @(negedge clk);
        end
        imem_ack     = 1'b0;
        branch_valid = 1'b0;
        dec_ready    = 1'b0;
        chk("rnd_min_deliveries", {31'd0, deliveries >= 20}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
